id_ex_pipeline_register: RTL and testbench
==========================================

// Module: id_ex_pipeline_register
// PURPOSE
//  ID/EX pipeline stage register, directly upstream of the ALU control unit and the ALU.
//  Captures decoded control fields, ALUOp/function/shamt, operands and register IDs from ID.
//  Presents them to EX one cycle later.
//  Supports hold (stall), bubble insertion (flush) and a saturating bubble counter.
//  Optionally contains a load-use hazard detector.
// PARAMETERS
//  DATA_WIDTH   32  width of operand, immediate and PC+4 fields
//  COUNT_WIDTH  16  width of the saturating bubble counter
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   asynchronous active-low reset
//  Stall          in   1   hold all EX outputs this cycle
//  Flush          in   1   load a bubble this cycle
//  ID_Valid       in   1   ID holds a real instruction
//  ID_ALUOp       in   3   ALU op class from main control
//  ID_ALUFunction in   6   instr[5:0]
//  ID_Shamt       in   5   instr[10:6]
//  ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst, ID_Jump
//                 in   1 each   main control strobes
//  ID_ReadData1   in   DATA_WIDTH   rs value
//  ID_ReadData2   in   DATA_WIDTH   rt value
//  ID_Immediate   in   DATA_WIDTH   sign/zero-extended immediate
//  ID_PC4         in   DATA_WIDTH   PC+4
//  ID_Rs, ID_Rt, ID_Rd    in   5 each   register numbers
//  EX_*           out  same as ID_*  registered copies of every ID_* input (incl. EX_Valid)
//  HazardStall    out  1   load-use hazard: freeze PC and IF/ID, bubble EX
//  BubbleCount    out  COUNT_WIDTH   bubbles inserted since reset, saturating
// BEHAVIOUR
//  Bubble value:
//    EX_ALUOp=3'b111, EX_ALUFunction=6'b000000 (SLL nop), EX_Shamt=0
//    all control strobes 0, EX_Valid=0
//    data fields 0, EX_Rs/Rt/Rd=0
//  reset=0:
//    all EX_* take the bubble value immediately (async), BubbleCount=0
//    HazardStall follows its combinational definition
//  Each rising clk edge, priority Flush > HazardStall > Stall > load:
//    Flush=1        -> load bubble; BubbleCount+1
//    HazardStall=1  -> load bubble; BubbleCount+1
//    Stall=1        -> all EX_* hold; BubbleCount holds
//    else           -> EX_* <= ID_*
//  Flush and Stall asserted together: Flush wins, bubble loaded.
//  Latency is exactly one cycle, ID to EX.
//  No combinational path from ID_* to EX_*.
//  BubbleCount saturates at all-ones; it never wraps.
//  Reset asserted mid-stall or mid-flush: bubble value immediately; counter cleared.
//  EX_ALUOp/EX_ALUFunction feed ALU control unchanged; a bubble must decode to SLL (4'b0111), never JR.
// CONFIGURATION
//  LOAD_USE_HAZARD_EN defined:
//    HazardStall = EX_Valid & EX_MemRead & (EX_Rt!=0) & (EX_Rt==ID_Rs | EX_Rt==ID_Rt) & ID_Valid
//    Combinational from current EX_* and ID_* state.
//    When active, the upstream stage must freeze PC and IF/ID.
//  LOAD_USE_HAZARD_EN undefined:
//    HazardStall tied 0; port still present.
//    Bubbles come from Flush only.
// TESTING
//  1. reset=0 with arbitrary ID_* -> EX_ALUOp=111, EX_ALUFunction=000000, EX_RegWrite=0, EX_Valid=0, BubbleCount=0.
//  2. Load ID ADD (ALUOp=111, funct=100000, Rd=5, ReadData1=7), Stall=Flush=0
//     -> next edge EX_* match, EX_Valid=1; then Stall=1 for 3 edges with new ID -> EX unchanged.
//  3. Flush=1 and Stall=1 together -> bubble loaded, BubbleCount 0->1.
//  4. (EN) EX holds LW Rt=8, MemRead=1; ID_Rs=8 -> HazardStall=1, next edge bubble, BubbleCount+1.
//     Same with EX_Rt=0 -> HazardStall=0.
//  5. COUNT_WIDTH=2, Flush=1 for 5 edges -> BubbleCount 1,2,3,3,3.
//  6. Assert reset mid-operation with EX_MemWrite=1 -> EX_MemWrite=0 before next clk edge; release -> normal loading resumes.

Source files
------------

// File: rtl/id_ex_pipeline_register.sv
// -----------------------------------------------------------------------------
// id_ex_pipeline_register
//
// ID/EX pipeline stage register. Captures the decoded control strobes, the
// ALU op class / function / shift amount, the operands and the register
// numbers produced by ID and presents them to EX exactly one cycle later.
// There is no combinational path from any ID_* input to any EX_* output.
//
// Per-edge priority:  Flush > HazardStall > Stall > load.
//   Flush / HazardStall : load a bubble and bump BubbleCount (saturating)
//   Stall               : hold every EX_* output and the counter
//   otherwise           : EX_* <= ID_*
//
// Bubble value: ALUOp=3'b111 with function 6'b000000 and shamt 0, which the
// ALU control unit decodes as SLL (a nop), never as JR. All strobes, data
// fields and register numbers are zero and EX_Valid is 0.
//
// Optional feature, macro LOAD_USE_HAZARD_EN:
//   defined   : HazardStall flags a load in EX whose destination (Rt, non-zero)
//               is a source of the valid instruction in ID. Combinational from
//               the current EX register contents and the ID inputs.
//   undefined : HazardStall is tied low; bubbles come from Flush only.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset (EX_* -> bubble, count -> 0)
//   Stall, Flush        hold / bubble requests
//   ID_*                decoded fields from the ID stage
//   EX_*                registered copies of ID_* (incl. EX_Valid)
//   HazardStall         load-use hazard: upstream freezes PC and IF/ID
//   BubbleCount         bubbles inserted since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module id_ex_pipeline_register #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   Stall,
   input  logic                   Flush,

   input  logic                   ID_Valid,
   input  logic [2:0]             ID_ALUOp,
   input  logic [5:0]             ID_ALUFunction,
   input  logic [4:0]             ID_Shamt,
   input  logic                   ID_RegWrite,
   input  logic                   ID_MemRead,
   input  logic                   ID_MemWrite,
   input  logic                   ID_MemtoReg,
   input  logic                   ID_ALUSrc,
   input  logic                   ID_RegDst,
   input  logic                   ID_Jump,
   input  logic [DATA_WIDTH-1:0]  ID_ReadData1,
   input  logic [DATA_WIDTH-1:0]  ID_ReadData2,
   input  logic [DATA_WIDTH-1:0]  ID_Immediate,
   input  logic [DATA_WIDTH-1:0]  ID_PC4,
   input  logic [4:0]             ID_Rs,
   input  logic [4:0]             ID_Rt,
   input  logic [4:0]             ID_Rd,

   output logic                   EX_Valid,
   output logic [2:0]             EX_ALUOp,
   output logic [5:0]             EX_ALUFunction,
   output logic [4:0]             EX_Shamt,
   output logic                   EX_RegWrite,
   output logic                   EX_MemRead,
   output logic                   EX_MemWrite,
   output logic                   EX_MemtoReg,
   output logic                   EX_ALUSrc,
   output logic                   EX_RegDst,
   output logic                   EX_Jump,
   output logic [DATA_WIDTH-1:0]  EX_ReadData1,
   output logic [DATA_WIDTH-1:0]  EX_ReadData2,
   output logic [DATA_WIDTH-1:0]  EX_Immediate,
   output logic [DATA_WIDTH-1:0]  EX_PC4,
   output logic [4:0]             EX_Rs,
   output logic [4:0]             EX_Rt,
   output logic [4:0]             EX_Rd,

   output logic                   HazardStall,
   output logic [COUNT_WIDTH-1:0] BubbleCount
);

   typedef struct packed {
      logic                  valid;
      logic [2:0]            alu_op;
      logic [5:0]            alu_func;
      logic [4:0]            shamt;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  memto_reg;
      logic                  alu_src;
      logic                  reg_dst;
      logic                  jump;
      logic [DATA_WIDTH-1:0] read_data1;
      logic [DATA_WIDTH-1:0] read_data2;
      logic [DATA_WIDTH-1:0] immediate;
      logic [DATA_WIDTH-1:0] pc4;
      logic [4:0]            rs;
      logic [4:0]            rt;
      logic [4:0]            rd;
   } ex_fields_t;

   // ALUOp 3'b111 defers to the function field; function 0 with shamt 0 is
   // SLL $0,$0,0 -- a true nop that can never be mistaken for JR (funct 001000).
   function automatic ex_fields_t bubble_value();
      ex_fields_t b;
      b          = '0;
      b.alu_op   = 3'b111;
      b.alu_func = 6'b000000;
      b.shamt    = 5'd0;
      return b;
   endfunction

   ex_fields_t             ex_q;
   ex_fields_t             ex_d;
   ex_fields_t             id_fields;
   logic [COUNT_WIDTH-1:0] bubble_cnt_q;
   logic [COUNT_WIDTH-1:0] bubble_cnt_d;
   logic                   hazard;
   logic                   load_bubble;

   always_comb begin
      id_fields            = '0;
      id_fields.valid      = ID_Valid;
      id_fields.alu_op     = ID_ALUOp;
      id_fields.alu_func   = ID_ALUFunction;
      id_fields.shamt      = ID_Shamt;
      id_fields.reg_write  = ID_RegWrite;
      id_fields.mem_read   = ID_MemRead;
      id_fields.mem_write  = ID_MemWrite;
      id_fields.memto_reg  = ID_MemtoReg;
      id_fields.alu_src    = ID_ALUSrc;
      id_fields.reg_dst    = ID_RegDst;
      id_fields.jump       = ID_Jump;
      id_fields.read_data1 = ID_ReadData1;
      id_fields.read_data2 = ID_ReadData2;
      id_fields.immediate  = ID_Immediate;
      id_fields.pc4        = ID_PC4;
      id_fields.rs         = ID_Rs;
      id_fields.rt         = ID_Rt;
      id_fields.rd         = ID_Rd;
   end

`ifdef LOAD_USE_HAZARD_EN
   // A load in EX writes Rt; if the instruction in ID reads that register the
   // loaded value is not available in time, so ID must wait one cycle.
   // Register 0 is hard-wired and never creates a dependency.
   assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0)
                 & ((ex_q.rt == ID_Rs) | (ex_q.rt == ID_Rt)) & ID_Valid;
`else
   assign hazard = 1'b0;
`endif

   assign load_bubble = Flush | hazard;

   always_comb begin
      ex_d         = ex_q;
      bubble_cnt_d = bubble_cnt_q;
      if (load_bubble) begin
         ex_d = bubble_value();
         if (bubble_cnt_q != {COUNT_WIDTH{1'b1}}) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
         end
      end else if (!Stall) begin
         ex_d = id_fields;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q         <= bubble_value();
         bubble_cnt_q <= '0;
      end else begin
         ex_q         <= ex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign EX_Valid       = ex_q.valid;
   assign EX_ALUOp       = ex_q.alu_op;
   assign EX_ALUFunction = ex_q.alu_func;
   assign EX_Shamt       = ex_q.shamt;
   assign EX_RegWrite    = ex_q.reg_write;
   assign EX_MemRead     = ex_q.mem_read;
   assign EX_MemWrite    = ex_q.mem_write;
   assign EX_MemtoReg    = ex_q.memto_reg;
   assign EX_ALUSrc      = ex_q.alu_src;
   assign EX_RegDst      = ex_q.reg_dst;
   assign EX_Jump        = ex_q.jump;
   assign EX_ReadData1   = ex_q.read_data1;
   assign EX_ReadData2   = ex_q.read_data2;
   assign EX_Immediate   = ex_q.immediate;
   assign EX_PC4         = ex_q.pc4;
   assign EX_Rs          = ex_q.rs;
   assign EX_Rt          = ex_q.rt;
   assign EX_Rd          = ex_q.rd;

   assign HazardStall    = hazard;
   assign BubbleCount    = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
module tb_id_ex_pipeline_register;
   localparam int DW = 32;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          Stall, Flush;
   logic          ID_Valid;
   logic [2:0]    ID_ALUOp;
   logic [5:0]    ID_ALUFunction;
   logic [4:0]    ID_Shamt;
   logic          ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst, ID_Jump;
   logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Immediate, ID_PC4;
   logic [4:0]    ID_Rs, ID_Rt, ID_Rd;

   logic          EX_Valid;
   logic [2:0]    EX_ALUOp;
   logic [5:0]    EX_ALUFunction;
   logic [4:0]    EX_Shamt;
   logic          EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_ALUSrc, EX_RegDst, EX_Jump;
   logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Immediate, EX_PC4;
   logic [4:0]    EX_Rs, EX_Rt, EX_Rd;
   logic          HazardStall;
   logic [CW-1:0] BubbleCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_register #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
      .ID_Valid(ID_Valid), .ID_ALUOp(ID_ALUOp), .ID_ALUFunction(ID_ALUFunction), .ID_Shamt(ID_Shamt),
      .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
      .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_Jump(ID_Jump),
      .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Immediate(ID_Immediate),
      .ID_PC4(ID_PC4), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd),
      .EX_Valid(EX_Valid), .EX_ALUOp(EX_ALUOp), .EX_ALUFunction(EX_ALUFunction), .EX_Shamt(EX_Shamt),
      .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
      .EX_MemtoReg(EX_MemtoReg), .EX_ALUSrc(EX_ALUSrc), .EX_RegDst(EX_RegDst), .EX_Jump(EX_Jump),
      .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_Immediate(EX_Immediate),
      .EX_PC4(EX_PC4), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd),
      .HazardStall(HazardStall), .BubbleCount(BubbleCount)
   );

   // Advance one clock and settle just after the edge; inputs change here too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_instr(input logic v, input logic [2:0] op, input logic [5:0] fn,
                              input logic [4:0] sh, input logic [6:0] strobes,
                              input logic [31:0] d1, input logic [31:0] d2,
                              input logic [31:0] imm, input logic [31:0] pc4,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      // strobes = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Jump}
      ID_Valid       = v;
      ID_ALUOp       = op;
      ID_ALUFunction = fn;
      ID_Shamt       = sh;
      {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst, ID_Jump} = strobes;
      ID_ReadData1   = d1;
      ID_ReadData2   = d2;
      ID_Immediate   = imm;
      ID_PC4         = pc4;
      ID_Rs          = rs;
      ID_Rt          = rt;
      ID_Rd          = rd;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      Stall = 1'b0;
      Flush = 1'b0;
      drive_instr(1'b1, 3'b111, 6'b100000, 5'd3, 7'b1000010, 32'd7, 32'd3, 32'h20, 32'h104, 5'd1, 5'd2, 5'd5);
      tick();
      tick();
      checks++;
      if ({EX_Valid, EX_ALUOp, EX_ALUFunction, EX_Shamt, EX_RegWrite} !== {1'b0, 3'b111, 6'b000000, 5'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_ctrl: got valid=%b op=%b fn=%b sh=%0d rw=%b, need 0 111 000000 0 0",
                  EX_Valid, EX_ALUOp, EX_ALUFunction, EX_Shamt, EX_RegWrite);
      end
      checks++;
      if ({EX_ReadData1, EX_Rd, BubbleCount} !== {32'd0, 5'd0, 2'd0}) begin
         errors++;
         $display("FAIL reset_data: got rd1=%0d rd=%0d cnt=%0d, need 0 0 0", EX_ReadData1, EX_Rd, BubbleCount);
      end
      reset = 1'b1;
   endtask

   task automatic test_load_stall();
      drive_instr(1'b1, 3'b111, 6'b100000, 5'd0, 7'b1000010, 32'd7, 32'd3, 32'h20, 32'h104, 5'd1, 5'd2, 5'd5);
      tick();
      checks++;
      if ({EX_Valid, EX_ALUOp, EX_ALUFunction, EX_Rd, EX_ReadData1, EX_ReadData2, EX_RegWrite, EX_RegDst}
          !== {1'b1, 3'b111, 6'b100000, 5'd5, 32'd7, 32'd3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL load_add: got v=%b op=%b fn=%b rd=%0d d1=%0d d2=%0d rw=%b rdst=%b, need 1 111 100000 5 7 3 1 1",
                  EX_Valid, EX_ALUOp, EX_ALUFunction, EX_Rd, EX_ReadData1, EX_ReadData2, EX_RegWrite, EX_RegDst);
      end
      checks++;
      if ({EX_Immediate, EX_PC4, EX_Rs, EX_Rt} !== {32'h20, 32'h104, 5'd1, 5'd2}) begin
         errors++;
         $display("FAIL load_add_misc: got imm=%h pc4=%h rs=%0d rt=%0d, need 20 104 1 2",
                  EX_Immediate, EX_PC4, EX_Rs, EX_Rt);
      end
      Stall = 1'b1;
      drive_instr(1'b1, 3'b111, 6'b100010, 5'd4, 7'b0000001, 32'd55, 32'd66, 32'h44, 32'h200, 5'd9, 5'd10, 5'd11);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({EX_Valid, EX_ALUFunction, EX_Rd, EX_ReadData1, EX_Jump, BubbleCount}
             !== {1'b1, 6'b100000, 5'd5, 32'd7, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got v=%b fn=%b rd=%0d d1=%0d j=%b cnt=%0d, need 1 100000 5 7 0 0",
                     i, EX_Valid, EX_ALUFunction, EX_Rd, EX_ReadData1, EX_Jump, BubbleCount);
         end
      end
   endtask

   task automatic test_flush_stall();
      Stall = 1'b1;
      Flush = 1'b1;
      tick();
      checks++;
      if ({EX_Valid, EX_ALUOp, EX_ALUFunction, EX_RegWrite, EX_ReadData1, EX_Rd, BubbleCount}
          !== {1'b0, 3'b111, 6'b000000, 1'b0, 32'd0, 5'd0, 2'd1}) begin
         errors++;
         $display("FAIL flush_over_stall: got v=%b op=%b fn=%b rw=%b d1=%0d rd=%0d cnt=%0d, need 0 111 000000 0 0 0 1",
                  EX_Valid, EX_ALUOp, EX_ALUFunction, EX_RegWrite, EX_ReadData1, EX_Rd, BubbleCount);
      end
      Stall = 1'b0;
      Flush = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0]  rds [3];
      logic [31:0] d1s [3];
      rds[0] = 5'd12; rds[1] = 5'd13; rds[2] = 5'd14;
      d1s[0] = 32'hAAAA0001; d1s[1] = 32'h5555FFFF; d1s[2] = 32'h00000123;
      for (int i = 0; i < 3; i++) begin
         drive_instr(1'b1, 3'b010, 6'b100101, 5'd0, 7'b1000010, d1s[i], 32'd1, 32'd0, 32'h300, 5'd3, 5'd4, rds[i]);
         tick();
         checks++;
         if ({EX_Valid, EX_ALUOp, EX_Rd, EX_ReadData1} !== {1'b1, 3'b010, rds[i], d1s[i]}) begin
            errors++;
            $display("FAIL b2b[%0d]: got v=%b op=%b rd=%0d d1=%h, need 1 010 %0d %h",
                     i, EX_Valid, EX_ALUOp, EX_Rd, EX_ReadData1, rds[i], d1s[i]);
         end
      end
   endtask

   task automatic test_load_use();
      logic          exp_hz;
      logic [CW-1:0] exp_cnt;
`ifdef LOAD_USE_HAZARD_EN
      exp_hz  = 1'b1;
      exp_cnt = 2'd2;
`else
      exp_hz  = 1'b0;
      exp_cnt = 2'd1;
`endif
      // LW $8, 0($1)
      drive_instr(1'b1, 3'b000, 6'b000000, 5'd0, 7'b1101100, 32'd100, 32'd0, 32'd0, 32'h400, 5'd1, 5'd8, 5'd0);
      tick();
      checks++;
      if ({EX_Valid, EX_MemRead, EX_Rt} !== {1'b1, 1'b1, 5'd8}) begin
         errors++;
         $display("FAIL lw_loaded: got v=%b mr=%b rt=%0d, need 1 1 8", EX_Valid, EX_MemRead, EX_Rt);
      end
      // ADD $9, $8, $3 depends on the load
      drive_instr(1'b1, 3'b111, 6'b100000, 5'd0, 7'b1000010, 32'd5, 32'd6, 32'd0, 32'h404, 5'd8, 5'd3, 5'd9);
      #1;
      checks++;
      if (HazardStall !== exp_hz) begin
         errors++;
         $display("FAIL hazard_detect: got %b, need %b", HazardStall, exp_hz);
      end
      tick();
      checks++;
      if ({EX_Valid, BubbleCount} !== {~exp_hz, exp_cnt}) begin
         errors++;
         $display("FAIL hazard_bubble: got v=%b cnt=%0d, need %b %0d", EX_Valid, BubbleCount, ~exp_hz, exp_cnt);
      end
      // LW $0 never creates a dependency
      drive_instr(1'b1, 3'b000, 6'b000000, 5'd0, 7'b1101100, 32'd100, 32'd0, 32'd0, 32'h408, 5'd1, 5'd0, 5'd0);
      tick();
      drive_instr(1'b1, 3'b111, 6'b100000, 5'd0, 7'b1000010, 32'd5, 32'd6, 32'd0, 32'h40C, 5'd0, 5'd0, 5'd9);
      #1;
      checks++;
      if ({HazardStall, EX_MemRead, EX_Rt} !== {1'b0, 1'b1, 5'd0}) begin
         errors++;
         $display("FAIL hazard_rt0: got hz=%b mr=%b rt=%0d, need 0 1 0", HazardStall, EX_MemRead, EX_Rt);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      // SW, then stall and assert reset between edges
      drive_instr(1'b1, 3'b000, 6'b000000, 5'd0, 7'b0010100, 32'd8, 32'd9, 32'd4, 32'h500, 5'd2, 5'd7, 5'd0);
      tick();
      checks++;
      if ({EX_MemWrite, EX_Valid} !== 2'b11) begin
         errors++;
         $display("FAIL sw_loaded: got mw=%b v=%b, need 1 1", EX_MemWrite, EX_Valid);
      end
      Stall = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({EX_MemWrite, EX_Valid, EX_ALUOp, BubbleCount} !== {1'b0, 1'b0, 3'b111, 2'd0}) begin
         errors++;
         $display("FAIL async_reset: got mw=%b v=%b op=%b cnt=%0d, need 0 0 111 0",
                  EX_MemWrite, EX_Valid, EX_ALUOp, BubbleCount);
      end
      #2;
      reset = 1'b1;
      Stall = 1'b0;
      tick();
      checks++;
      if ({EX_MemWrite, EX_Valid, EX_Rt, EX_ReadData2} !== {1'b1, 1'b1, 5'd7, 32'd9}) begin
         errors++;
         $display("FAIL resume_after_reset: got mw=%b v=%b rt=%0d d2=%0d, need 1 1 7 9",
                  EX_MemWrite, EX_Valid, EX_Rt, EX_ReadData2);
      end
   endtask

   task automatic test_saturation();
      logic [CW-1:0] exp [5];
      exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd3; exp[3] = 2'd3; exp[4] = 2'd3;
      Flush = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({BubbleCount, EX_Valid} !== {exp[i], 1'b0}) begin
            errors++;
            $display("FAIL saturate[%0d]: got cnt=%0d v=%b, need %0d 0", i, BubbleCount, EX_Valid, exp[i]);
         end
      end
      Flush = 1'b0;
      Stall = 1'b1;
      tick();
      checks++;
      if (BubbleCount !== 2'd3) begin
         errors++;
         $display("FAIL stall_holds_count: got %0d, need 3", BubbleCount);
      end
      Stall = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_stall();
      test_flush_stall();
      test_back_to_back();
      test_load_use();
      test_reset_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
